// File: rtl/max_pool_2d_stream.sv
// Streaming 2x2 stride-2 max/average pooling over raster-ordered signed pixels.
// One line buffer of horizontal pair results; one pooled pixel per window.
module max_pool_2d_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              mode,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] din,
    output logic              valid_out,
    output logic [DATA_W-1:0] dout,
    output logic              last_out
);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int NPAIR = IMG_W / 2;
    localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN_LAST = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_WIN_LAST = RW'(2 * (IMG_H / 2) - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          mode_q, mode_d;
    logic          valid_out_q, last_out_q;
    logic [DATA_W-1:0] dout_q;

    logic signed [DATA_W-1:0] h_q;
    logic signed [DATA_W:0]   lbuf_q [NPAIR];

    logic                     take, fire, fire_last;
    logic [PW-1:0]            pidx;
    logic signed [DATA_W-1:0] din_s, pmax;
    logic signed [DATA_W:0]   pair, prev, rmax;
    logic signed [DATA_W+1:0] sum4;
    logic [DATA_W-1:0]        res;

    assign take      = valid_in & ~clear;
    assign fire      = take & col_q[0] & row_q[0];
    assign fire_last = fire && (col_q == COL_WIN_LAST) && (row_q == ROW_WIN_LAST);
    assign pidx      = PW'(col_q >> 1);
    assign din_s     = $signed(din);

    // Horizontal pair is kept one bit wider so the average path never overflows.
    always_comb begin
        pmax = (h_q > din_s) ? h_q : din_s;
        pair = mode_q ? ($signed({h_q[DATA_W-1], h_q}) + $signed({din_s[DATA_W-1], din_s}))
                      : $signed({pmax[DATA_W-1], pmax});
        prev = lbuf_q[pidx];
        rmax = (prev > pair) ? prev : pair;
        sum4 = $signed({prev[DATA_W], prev}) + $signed({pair[DATA_W], pair});
        res  = mode_q ? DATA_W'(sum4 >>> 2) : DATA_W'(rmax);
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (valid_in) begin
            if (col_q == '0 && row_q == '0) mode_d = mode;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            valid_out_q <= fire;
            last_out_q  <= fire_last;
            if (fire) dout_q <= res;
        end
    end

    // Datapath storage is written before it is read in every frame, so no reset.
    always_ff @(posedge clk) begin
        if (take && !col_q[0]) h_q <= din_s;
        if (take && col_q[0] && !row_q[0]) lbuf_q[pidx] <= pair;
    end

    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;
    assign dout      = dout_q;
endmodule

// File: tb/tb_max_pool_2d_stream.sv
// Bench for max_pool_2d_stream: a 4x4 and a 5x5 instance, each checked every
// cycle against a frame-array model plus literal expectations for known frames.
module tb_max_pool_2d_stream;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         clr, md, vin, vo, lo;
    logic [1:0][DW-1:0] di, dq;

    max_pool_2d_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]), .mode(md[0]), .valid_in(vin[0]),
        .din(di[0]), .valid_out(vo[0]), .dout(dq[0]), .last_out(lo[0]));
    max_pool_2d_stream #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clr[1]), .mode(md[1]), .valid_in(vin[1]),
        .din(di[1]), .valid_out(vo[1]), .dout(dq[1]), .last_out(lo[1]));

    int nvec = 0, nfail = 0;
    int W[2] = '{4, 5};
    int H[2] = '{4, 5};

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            if (nfail <= 40) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int fdiv4(int s);
        return (s >= 0) ? s / 4 : -((3 - s) / 4);
    endfunction

    // Reference: remember the frame as a 2-D image, pool each 2x2 block when its
    // bottom-right pixel arrives.
    int   k[2];
    bit   mq[2];
    int   img[2][8][8];
    logic [1:0] ev, el;
    int   ed[2];
    int   elog[2][$];
    int   dlog[2][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                k[d] = 0; mq[d] = 0; ev[d] <= 1'b0; el[d] <= 1'b0; ed[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                ev[d] <= 1'b0;
                el[d] <= 1'b0;
                if (clr[d]) k[d] = 0;
                else if (vin[d]) begin
                    int r, c, v, s, mx;
                    r = k[d] / W[d];
                    c = k[d] % W[d];
                    if (k[d] == 0) mq[d] = md[d];
                    img[d][r][c] = $signed(di[d]);
                    if (r % 2 == 1 && c % 2 == 1) begin
                        s  = img[d][r-1][c-1] + img[d][r-1][c] + img[d][r][c-1] + img[d][r][c];
                        mx = img[d][r-1][c-1];
                        if (img[d][r-1][c] > mx) mx = img[d][r-1][c];
                        if (img[d][r][c-1] > mx) mx = img[d][r][c-1];
                        if (img[d][r][c]   > mx) mx = img[d][r][c];
                        v = mq[d] ? fdiv4(s) : mx;
                        ev[d] <= 1'b1;
                        ed[d] <= v;
                        el[d] <= (r == 2 * (H[d] / 2) - 1) && (c == 2 * (W[d] / 2) - 1);
                        elog[d].push_back(v);
                    end
                    k[d] = (k[d] + 1) % (W[d] * H[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("valid_out[%0d]", d), int'(vo[d]), int'(ev[d]));
                chk($sformatf("last_out[%0d]", d), int'(lo[d]), int'(el[d]));
                chk($sformatf("dout[%0d]", d), int'($signed(dq[d])), ed[d]);
                if (vo[d]) dlog[d].push_back(int'($signed(dq[d])));
            end
        end
    end

    task automatic step(int d, bit v, int val, bit m, bit c);
        @(negedge clk);
        vin[d] = v;
        di[d]  = val[DW-1:0];
        md[d]  = m;
        clr[d] = c;
    endtask

    task automatic idle(int d, int n);
        for (int i = 0; i < n; i++) step(d, 0, 0, md[d], 0);
    endtask

    // gaps: 0 none, 1 every other cycle, 2 random
    task automatic frame(int d, int px[$], bit m0, bit m1, int sw, int gaps);
        foreach (px[i]) begin
            step(d, 1, px[i], (i < sw) ? m0 : m1, 0);
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) step(d, 0, 0, m1, 0);
        end
        step(d, 0, 0, m1, 0);
    endtask

    task automatic check_log(int d, string nm, int e[$]);
        idle(d, 2);
        chk({nm, " dut count"}, dlog[d].size(), e.size());
        chk({nm, " model count"}, elog[d].size(), e.size());
        foreach (e[i]) begin
            if (i < dlog[d].size()) chk($sformatf("%s dut[%0d]", nm, i), dlog[d][i], e[i]);
            if (i < elog[d].size()) chk($sformatf("%s model[%0d]", nm, i), elog[d][i], e[i]);
        end
        dlog[d].delete();
        elog[d].delete();
    endtask

    function automatic void ramp(output int q[$], input int n);
        q.delete();
        for (int i = 1; i <= n; i++) q.push_back(i);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int q[$], q2[$];
        clr = '0; md = '0; vin = '0; di = '0;
        #1 rst_n = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset valid_out[%0d]", d), int'(vo[d]), 0);
            chk($sformatf("reset dout[%0d]", d), int'(dq[d]), 0);
            chk($sformatf("reset last_out[%0d]", d), int'(lo[d]), 0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle(0, 1);

        ramp(q, 16);
        frame(0, q, 0, 0, 0, 0);
        check_log(0, "max 4x4", '{6, 8, 14, 16});
        frame(0, q, 1, 1, 0, 0);
        check_log(0, "avg 4x4", '{3, 5, 11, 13});

        q = '{-128, -1, 0, 0, -3, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        frame(0, q, 0, 0, 0, 0);
        check_log(0, "signed max", '{-1, 0, 0, 0});
        frame(0, q, 1, 1, 0, 0);
        check_log(0, "signed avg", '{-34, 0, 0, 0});
        q = '{-1, -2, 0, 0, -3, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        frame(0, q, 1, 1, 0, 0);
        check_log(0, "floor avg", '{-3, 0, 0, 0});

        ramp(q, 25);
        frame(1, q, 0, 0, 0, 1);
        frame(1, q, 0, 0, 0, 1);
        check_log(1, "5x5 gaps", '{7, 9, 17, 19, 7, 9, 17, 19});

        ramp(q, 16);
        frame(0, q, 0, 1, 2, 0);
        check_log(0, "mode ignored midframe", '{6, 8, 14, 16});
        frame(0, q, 1, 1, 0, 0);
        check_log(0, "mode relatched", '{3, 5, 11, 13});

        // clear with a valid pixel at pixel 10
        for (int i = 1; i <= 9; i++) step(0, 1, i, 0, 0);
        idle(0, 2);
        dlog[0].delete(); elog[0].delete();
        step(0, 1, 10, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("valid_out after clear", int'(vo[0]), 0);
        frame(0, q, 0, 0, 0, 0);
        check_log(0, "after clear", '{6, 8, 14, 16});

        // asynchronous reset while an output is being presented
        for (int i = 1; i <= 6; i++) step(0, 1, i, 0, 0);
        @(posedge clk);
        #1;
        chk("pre-reset valid_out", int'(vo[0]), 1);
        chk("pre-reset dout", int'($signed(dq[0])), 6);
        rst_n = 1'b0;
        #1;
        chk("midframe reset valid_out", int'(vo[0]), 0);
        chk("midframe reset dout", int'(dq[0]), 0);
        chk("midframe reset last_out", int'(lo[0]), 0);
        vin = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dlog[0].delete(); elog[0].delete();
        frame(0, q, 0, 0, 0, 0);
        check_log(0, "after reset", '{6, 8, 14, 16});

        // randomized frames on both instances, checked cycle by cycle
        for (int f = 0; f < 12; f++) begin
            int d;
            bit m0, m1;
            d  = f % 2;
            m0 = 1'($urandom_range(0, 1));
            m1 = 1'($urandom_range(0, 1));
            q2.delete();
            for (int i = 0; i < W[d] * H[d]; i++) q2.push_back(int'($urandom_range(0, 255)) - 128);
            frame(d, q2, m0, m1, int'($urandom_range(0, 5)), 2);
        end
        idle(0, 3);
        chk("random frames output count", dlog[0].size() + dlog[1].size(), 6 * 4 + 6 * 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
